// File: rtl/dp_mem_pkg.sv
// Shared constants for the true dual-port RAM.
//   RD_FIRST / WR_FIRST : cross-port same-cycle read returns old / new word
//   PRIO_A / PRIO_B     : owner of a byte written by both ports in one cycle
//   COLL_CNT_W          : width of the saturating collision counter
package dp_mem_pkg;
  localparam int RD_FIRST   = 0;
  localparam int WR_FIRST   = 1;
  localparam int PRIO_A     = 0;
  localparam int PRIO_B     = 1;
  localparam int COLL_CNT_W = 16;
endpackage

// File: rtl/dp_mem_rd_pipe.sv
// Per-port read-return pipeline, STAGES deep.
//   clk, rst_n        : clock, async active-low reset (drops in-flight reads)
//   in_vld, in_data   : read strobe and resolved array data at access time
//   out_vld, out_data : one-cycle valid pulse; data holds between reads
module dp_mem_rd_pipe #(
  parameter int DATA_W = 8,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_data
);
  logic [STAGES:1]   vld_pipe;
  logic [DATA_W-1:0] dat_pipe [1:STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int s = 1; s <= STAGES; s++) dat_pipe[s] <= '0;
    end else begin
      vld_pipe[1] <= in_vld;
      if (in_vld) dat_pipe[1] <= in_data;
      // data only advances alongside its valid, so each stage holds the last read
      for (int s = 2; s <= STAGES; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
      end
    end
  end

  assign out_vld  = vld_pipe[STAGES];
  assign out_data = dat_pipe[STAGES];
endmodule

// File: rtl/dual_port_ram_tdp.sv
// True dual-port RAM: one shared array, ports A and B, single clock.
//   clk_pi, rst_ni                 : clock, async active-low reset
//   addr/data/en/we/be_{a,b}_i     : per-port request (be used on writes)
//   data_{a,b}_o, rvalid_{a,b}_o   : read return after READ_LAT cycles
//   collision_o, coll_cnt_o        : same-address-with-write report, saturating count
module dual_port_ram_tdp
  import dp_mem_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int DEPTH    = 8,
  parameter int READ_LAT = 1,
  parameter int RD_MODE  = RD_FIRST,
  parameter int WR_PRIO  = PRIO_A
) (
  input  logic                  clk_pi,
  input  logic                  rst_ni,
  input  logic [ADDR_W-1:0]     addr_a_i,
  input  logic [DATA_W-1:0]     data_a_i,
  input  logic                  en_a_i,
  input  logic                  we_a_i,
  input  logic [DATA_W/8-1:0]   be_a_i,
  output logic [DATA_W-1:0]     data_a_o,
  output logic                  rvalid_a_o,
  input  logic [ADDR_W-1:0]     addr_b_i,
  input  logic [DATA_W-1:0]     data_b_i,
  input  logic                  en_b_i,
  input  logic                  we_b_i,
  input  logic [DATA_W/8-1:0]   be_b_i,
  output logic [DATA_W-1:0]     data_b_o,
  output logic                  rvalid_b_o,
  output logic                  collision_o,
  output logic [COLL_CNT_W-1:0] coll_cnt_o
);
  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
    $error("dual_port_ram_tdp: READ_LAT must be 1 or 2");
  end
  if (DATA_W % 8 != 0) begin : g_bad_dw
    $error("dual_port_ram_tdp: DATA_W must be a multiple of 8");
  end
  if (DEPTH > (1 << ADDR_W)) begin : g_bad_depth
    $error("dual_port_ram_tdp: DEPTH exceeds address space");
  end

  typedef struct packed {
    logic              en;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  req_t req_a, req_b;
  assign req_a = '{en: en_a_i, we: we_a_i, be: be_a_i, addr: addr_a_i, data: data_a_i};
  assign req_b = '{en: en_b_i, we: we_b_i, be: be_b_i, addr: addr_b_i, data: data_b_i};

  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_a, in_b, wr_a, wr_b, rd_a, rd_b, same, coll;
  logic [IDX_W-1:0]  idx_a, idx_b;
  logic [DATA_W-1:0] old_a, old_b, post_a, post_b, rdat_a, rdat_b;

  assign in_a  = 32'(req_a.addr) < DEPTH;
  assign in_b  = 32'(req_b.addr) < DEPTH;
  assign idx_a = req_a.addr[IDX_W-1:0];
  assign idx_b = req_b.addr[IDX_W-1:0];
  assign wr_a  = req_a.en & req_a.we & in_a;
  assign wr_b  = req_b.en & req_b.we & in_b;
  assign rd_a  = req_a.en & ~req_a.we;
  assign rd_b  = req_b.en & ~req_b.we;
  assign same  = req_a.addr == req_b.addr;
  // be=0 writes still qualify; out-of-range never does
  assign coll  = req_a.en & req_b.en & in_a & in_b & same & (req_a.we | req_b.we);

  // Byte owner: a byte written by both ports goes to the WR_PRIO port.
  function automatic logic [7:0] pick(logic [7:0] old, logic ta, logic [7:0] da,
                                      logic tb, logic [7:0] db);
    if (ta && (!tb || WR_PRIO == PRIO_A)) return da;
    if (tb) return db;
    return old;
  endfunction

  // post_x is the word at port x's address after this edge's writes from
  // both ports; it feeds both the array update and write-first reads.
  always_comb begin
    old_a  = in_a ? mem[idx_a] : '0;
    old_b  = in_b ? mem[idx_b] : '0;
    post_a = old_a;
    post_b = old_b;
    for (int k = 0; k < BE_W; k++) begin
      post_a[8*k +: 8] = pick(old_a[8*k +: 8],
                              wr_a & req_a.be[k], req_a.data[8*k +: 8],
                              wr_b & same & req_b.be[k], req_b.data[8*k +: 8]);
      post_b[8*k +: 8] = pick(old_b[8*k +: 8],
                              wr_a & same & req_a.be[k], req_a.data[8*k +: 8],
                              wr_b & req_b.be[k], req_b.data[8*k +: 8]);
    end
  end

  assign rdat_a = !in_a ? '0 : (RD_MODE == WR_FIRST) ? post_a : old_a;
  assign rdat_b = !in_b ? '0 : (RD_MODE == WR_FIRST) ? post_b : old_b;

  // Contents are not reset; both ports hitting one word write the same value.
  always_ff @(posedge clk_pi) begin
    if (wr_a) mem[idx_a] <= post_a;
    if (wr_b) mem[idx_b] <= post_b;
  end

  always_ff @(posedge clk_pi or negedge rst_ni) begin
    if (!rst_ni) begin
      collision_o <= 1'b0;
      coll_cnt_o  <= '0;
    end else begin
      collision_o <= coll;
      if (coll && coll_cnt_o != '1) coll_cnt_o <= coll_cnt_o + 1'b1;
    end
  end

  dp_mem_rd_pipe #(.DATA_W(DATA_W), .STAGES(READ_LAT)) u_pipe_a (
    .clk(clk_pi), .rst_n(rst_ni), .in_vld(rd_a), .in_data(rdat_a),
    .out_vld(rvalid_a_o), .out_data(data_a_o)
  );

  dp_mem_rd_pipe #(.DATA_W(DATA_W), .STAGES(READ_LAT)) u_pipe_b (
    .clk(clk_pi), .rst_n(rst_ni), .in_vld(rd_b), .in_data(rdat_b),
    .out_vld(rvalid_b_o), .out_data(data_b_o)
  );
endmodule
